// File: rtl/sw_debounce_if.sv
// Switch-conditioner bus: raw active-low switches in, debounced level and
// press/release strobes out. "rel" carries the release strobe because
// "release" is a reserved word in SystemVerilog.
interface sw_debounce_if #(
  parameter int N = 3
);
  logic [N-1:0] sw;
  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] rel;

  modport master (output sw, input level, press, rel);
  modport slave  (input sw, output level, press, rel);
endinterface

// File: rtl/sw_debounce.sv
// sw_debounce: synchronises active-low push switches, filters bounce, and
// produces an active-high debounced level plus one-cycle press/release strobes.
// Optional feature: define SW_DEBOUNCE_AUTOREPEAT_EN to build the press
// auto-repeat logic (REPEAT_DLY / REPEAT_PER are ignored otherwise).
module sw_debounce #(
  parameter int N          = 3,
  parameter int CNT_W      = 20,
  parameter int STABLE_CNT = 1000000,
  parameter int REPEAT_DLY = 12500000,
  parameter int REPEAT_PER = 2500000
) (
  input  logic            clk,
  input  logic            rst,
  sw_debounce_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHK_DN = 2'd1,
    HELD   = 2'd2,
    CHK_UP = 2'd3
  } state_t;

  // The count that precedes acceptance: the edge that sees this value while
  // the sample still disagrees is the STABLE_CNT-th disagreeing sample.
  localparam logic [CNT_W-1:0] ACCEPT_AT = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Nonsensical configurations produce an obviously named empty block.
  if (STABLE_CNT < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_cfg
  end

  logic [N-1:0] sync1;
  logic [N-1:0] sync2;
  logic [N-1:0] level_v;
  logic [N-1:0] press_v;
  logic [N-1:0] rel_v;

  // Two-flop synchroniser on the inverted (active-high) switch lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ~bus.sw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_q, level_nxt;
    logic             press_q, press_nxt;
    logic             rel_q, rel_nxt;
    logic             s;
    logic             accept;
`ifdef SW_DEBOUNCE_AUTOREPEAT_EN
    localparam logic [23:0] DLY_AT = 24'(REPEAT_DLY - 1);
    localparam logic [23:0] PER_AT = 24'(REPEAT_PER - 1);
    logic [23:0] rpt, rpt_nxt;
    logic        armed, armed_nxt;
`endif

    assign s      = sync2[i];
    assign accept = (s != level_q) && (cnt >= ACCEPT_AT);

    // Channel state, stability counter, level and strobe registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state   <= IDLE;
        cnt     <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
`ifdef SW_DEBOUNCE_AUTOREPEAT_EN
        rpt     <= '0;
        armed   <= 1'b0;
`endif
      end else begin
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        level_q <= level_nxt;
        press_q <= press_nxt;
        rel_q   <= rel_nxt;
`ifdef SW_DEBOUNCE_AUTOREPEAT_EN
        rpt     <= rpt_nxt;
        armed   <= armed_nxt;
`endif
      end
    end

    // Next-state, counter and strobe decisions for this channel.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      level_nxt = level_q;
      press_nxt = 1'b0;
      rel_nxt   = 1'b0;
`ifdef SW_DEBOUNCE_AUTOREPEAT_EN
      rpt_nxt   = rpt;
      armed_nxt = armed;
`endif
      if (s == level_q) begin
        cnt_nxt = '0;
      end else if (cnt != CNT_MAX) begin
        cnt_nxt = cnt + 1'b1;
      end

      case (state)
        IDLE, CHK_DN: begin
          if (!s) begin
            state_nxt = IDLE;
          end else if (accept) begin
            state_nxt = HELD;
            level_nxt = 1'b1;
            press_nxt = 1'b1;
            cnt_nxt   = '0;
          end else begin
            state_nxt = CHK_DN;
          end
        end
        HELD, CHK_UP: begin
          if (s) begin
            state_nxt = HELD;
          end else if (accept) begin
            state_nxt = IDLE;
            level_nxt = 1'b0;
            rel_nxt   = 1'b1;
            cnt_nxt   = '0;
          end else begin
            state_nxt = CHK_UP;
          end
        end
        default: state_nxt = IDLE;
      endcase

`ifdef SW_DEBOUNCE_AUTOREPEAT_EN
      if (press_nxt || rel_nxt) begin
        rpt_nxt   = '0;
        armed_nxt = 1'b0;
      end else if (state == HELD || state == CHK_UP) begin
        if (rpt == (armed ? PER_AT : DLY_AT)) begin
          press_nxt = 1'b1;
          rpt_nxt   = '0;
          armed_nxt = 1'b1;
        end else begin
          rpt_nxt = rpt + 1'b1;
        end
      end
`endif
    end

    assign level_v[i] = level_q;
    assign press_v[i] = press_q;
    assign rel_v[i]   = rel_q;
  end

  assign bus.level = level_v;
  assign bus.press = press_v;
  assign bus.rel   = rel_v;

endmodule

// File: tb/tb_sw_debounce.sv
// Testbench for sw_debounce: expected strobes are queued with the cycle they
// must appear on and checked by a monitor as the DUT produces them.
module tb_sw_debounce;
  localparam int N      = 3;
  localparam int STABLE = 4;
  localparam int DLY    = 10;
  localparam int PER    = 5;
  localparam int LAT    = STABLE + 2;

  typedef struct {
    int         cyc;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] level;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   failures = 0;
  exp_t sbq[$];

  sw_debounce_if #(.N(N)) bus();

  sw_debounce #(
    .N(N), .CNT_W(20), .STABLE_CNT(STABLE), .REPEAT_DLY(DLY), .REPEAT_PER(PER)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock and edge counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard monitor: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() != 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      tests++;
      failures++;
      $display("[TB] FAIL missed_strobe: nothing at cycle %0d, need press=%b rel=%b", e.cyc, e.press, e.rel);
    end
    if ((bus.press | bus.rel) !== 3'b000) begin
      tests++;
      if (sbq.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_strobe: cycle %0d press=%b rel=%b, need none", cyc, bus.press, bus.rel);
      end else begin
        e = sbq.pop_front();
        if (e.cyc != cyc || bus.press !== e.press || bus.rel !== e.rel || bus.level !== e.level) begin
          failures++;
          $display("[TB] FAIL strobe: cycle %0d press=%b rel=%b level=%b, need cycle %0d press=%b rel=%b level=%b",
                   cyc, bus.press, bus.rel, bus.level, e.cyc, e.press, e.rel, e.level);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int at, input logic [2:0] p, input logic [2:0] r, input logic [2:0] l);
    exp_t e;
    e.cyc = at; e.press = p; e.rel = r; e.level = l;
    sbq.push_back(e);
  endtask

  task automatic drain(output bit ok);
    int k = 0;
    while (sbq.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    step(8);
    ok = (sbq.size() == 0);
    sbq.delete();
  endtask

  task automatic test_reset();
    bit ok;
    int c;
    rst = 1'b1;
    bus.sw = 3'b000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++;
      if ({bus.level, bus.press, bus.rel} !== 9'b0) begin
        failures++;
        $display("[TB] FAIL reset_outputs: level=%b press=%b rel=%b, need all 0", bus.level, bus.press, bus.rel);
      end
    end
    bus.sw = 3'b011;
    rst = 1'b0;
    c = cyc;
    push(c + LAT, 3'b100, 3'b000, 3'b100);
    drain(ok);
    tests++;
    if (!ok || bus.level !== 3'b100) begin
      failures++;
      $display("[TB] FAIL reset_release_press: level=%b drained=%0d, need level=100 drained=1", bus.level, ok);
    end
    bus.sw = 3'b111;
    c = cyc;
    push(c + LAT, 3'b000, 3'b100, 3'b000);
    drain(ok);
    tests++;
    if (!ok || bus.level !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_followup_release: level=%b drained=%0d, need level=000 drained=1", bus.level, ok);
    end
  endtask

  task automatic test_single_press();
    bit ok;
    int c;
    bus.sw = 3'b110;
    c = cyc;
    push(c + LAT, 3'b001, 3'b000, 3'b001);
    drain(ok);
    tests++;
    if (!ok || bus.level !== 3'b001) begin
      failures++;
      $display("[TB] FAIL single_press: level=%b drained=%0d, need level=001 drained=1", bus.level, ok);
    end
  endtask

  task automatic test_release_glitch();
    bit ok;
    int c;
    bus.sw = 3'b111;
    step(2);
    bus.sw = 3'b110;
    step(12);
    tests++;
    if (bus.level !== 3'b001) begin
      failures++;
      $display("[TB] FAIL release_glitch: level=%b, need 001", bus.level);
    end
    bus.sw = 3'b111;
    c = cyc;
    push(c + LAT, 3'b000, 3'b001, 3'b000);
    drain(ok);
    tests++;
    if (!ok || bus.level !== 3'b000) begin
      failures++;
      $display("[TB] FAIL release: level=%b drained=%0d, need level=000 drained=1", bus.level, ok);
    end
  endtask

  task automatic test_bounce();
    bit ok;
    int c;
    for (int k = 0; k < 5; k++) begin
      bus.sw = 3'b101;
      step(3);
      bus.sw = 3'b111;
      step(1);
    end
    bus.sw = 3'b101;
    c = cyc;
    push(c + LAT, 3'b010, 3'b000, 3'b010);
    drain(ok);
    tests++;
    if (!ok || bus.level !== 3'b010) begin
      failures++;
      $display("[TB] FAIL bounce_press: level=%b drained=%0d, need level=010 drained=1", bus.level, ok);
    end
    bus.sw = 3'b111;
    c = cyc;
    push(c + LAT, 3'b000, 3'b010, 3'b000);
    drain(ok);
    tests++;
    if (!ok || bus.level !== 3'b000) begin
      failures++;
      $display("[TB] FAIL bounce_release: level=%b drained=%0d, need level=000 drained=1", bus.level, ok);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int c;
    bus.sw = 3'b000;
    c = cyc;
    push(c + LAT, 3'b111, 3'b000, 3'b111);
    drain(ok);
    tests++;
    if (!ok || bus.level !== 3'b111) begin
      failures++;
      $display("[TB] FAIL simultaneous_press: level=%b drained=%0d, need level=111 drained=1", bus.level, ok);
    end
    bus.sw = 3'b111;
    c = cyc;
    push(c + LAT, 3'b000, 3'b111, 3'b000);
    drain(ok);
    tests++;
    if (!ok || bus.level !== 3'b000) begin
      failures++;
      $display("[TB] FAIL simultaneous_release: level=%b drained=%0d, need level=000 drained=1", bus.level, ok);
    end
  endtask

  task automatic test_reset_midcount();
    bit ok;
    int c;
    bus.sw = 3'b110;
    step(3);
    rst = 1'b1;
    step(2);
    tests++;
    if ({bus.level, bus.press, bus.rel} !== 9'b0) begin
      failures++;
      $display("[TB] FAIL midcount_reset_outputs: level=%b press=%b rel=%b, need all 0", bus.level, bus.press, bus.rel);
    end
    rst = 1'b0;
    c = cyc;
    push(c + LAT, 3'b001, 3'b000, 3'b001);
    drain(ok);
    tests++;
    if (!ok || bus.level !== 3'b001) begin
      failures++;
      $display("[TB] FAIL midcount_restart: level=%b drained=%0d, need level=001 drained=1", bus.level, ok);
    end
    bus.sw = 3'b111;
    c = cyc;
    push(c + LAT, 3'b000, 3'b001, 3'b000);
    drain(ok);
  endtask

  task automatic test_autorepeat();
    bit ok;
    int c;
    int t0;
    int rel_at;
    bus.sw = 3'b110;
    c = cyc;
    t0 = c + LAT;
    rel_at = t0 + 40;
    push(t0, 3'b001, 3'b000, 3'b001);
`ifdef SW_DEBOUNCE_AUTOREPEAT_EN
    for (int t = t0 + DLY; t < rel_at; t += PER) push(t, 3'b001, 3'b000, 3'b001);
`endif
    push(rel_at, 3'b000, 3'b001, 3'b000);
    step(40);
    bus.sw = 3'b111;
    drain(ok);
    tests++;
    if (!ok || bus.level !== 3'b000) begin
      failures++;
      $display("[TB] FAIL autorepeat: level=%b drained=%0d, need level=000 drained=1", bus.level, ok);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded, need completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    rst = 1'b1;
    bus.sw = 3'b111;
    test_reset();
    test_single_press();
    test_release_glitch();
    test_bounce();
    test_back_to_back();
    test_reset_midcount();
    test_autorepeat();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
